// File: rtl/iop_pkg.sv
// Shared definitions for the iop scheduler.
//   - Bit positions of the fields inside an iop word.
//   - Bit indices of the step-init flags that travel with each iop.
//   - The state enum used by the scheduler FSM.
//   - step_after(): given the current step, returns the next required step.
package iop_pkg;

  // Bit positions inside an iop word
  localparam int ALU_ST_MEM = 22;  // ALU result is stored to memory
  localparam int MEM_IS_RMW = 4;
  localparam int MEM_WIDTH  = 3;

  // Bit indices inside the 3-bit init flags
  localparam int INIT_ALU  = 2;  // ALU step valid
  localparam int INIT_NOLD = 1;  // operand needs no load
  localparam int INIT_AGU  = 0;  // address generation needed

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGU,
    ST_LOAD,
    ST_ALU,
    ST_STORE
  } state_t;

  // Next required step after 'cur' in the fixed order AGU, LOAD, ALU, STORE.
  // Pass ST_IDLE as 'cur' to get the first step of a fresh entry.
  // A result of ST_IDLE means no step remains.
  // The checks run from the last step to the first, so the earliest
  // applicable step overwrites any later one.
  function automatic state_t step_after(state_t cur, logic [2:0] init, logic st_mem);
    state_t nxt;
    nxt = ST_IDLE;
    if (st_mem && cur != ST_STORE)
      nxt = ST_STORE;
    if (init[INIT_ALU] && (cur == ST_IDLE || cur == ST_AGU || cur == ST_LOAD))
      nxt = ST_ALU;
    if (!init[INIT_NOLD] && (cur == ST_IDLE || cur == ST_AGU))
      nxt = ST_LOAD;
    if (init[INIT_AGU] && cur == ST_IDLE)
      nxt = ST_AGU;
    return nxt;
  endfunction

endpackage

// File: rtl/iop_scheduler_if.sv
// Bundles the decode-side and execution-side signals of the iop scheduler.
// Decode side:
//   - id_feed, id_iop, id_iop_init, flush (inputs to the scheduler)
//   - sq_hold, sq_empty, sq_busy (outputs)
// Execution side:
//   - ex_iop (output)
//   - {agu,ld,alu,st}_req out, {agu,ld,alu,st}_ack in
// Modports:
//   - master: the environment (decode unit and execution resources).
//   - slave: the scheduler.
interface iop_scheduler_if #(
  parameter int IOP_W = 32
);
  logic             id_feed;
  logic [IOP_W-1:0] id_iop;
  logic [2:0]       id_iop_init;
  logic             flush;
  logic             sq_hold;
  logic             sq_empty;
  logic             sq_busy;
  logic [IOP_W-1:0] ex_iop;
  logic             agu_req, agu_ack;
  logic             ld_req,  ld_ack;
  logic             alu_req, alu_ack;
  logic             st_req,  st_ack;

  modport master (
    output id_feed, id_iop, id_iop_init, flush,
    output agu_ack, ld_ack, alu_ack, st_ack,
    input  sq_hold, sq_empty, sq_busy, ex_iop,
    input  agu_req, ld_req, alu_req, st_req
  );

  modport slave (
    input  id_feed, id_iop, id_iop_init, flush,
    input  agu_ack, ld_ack, alu_ack, st_ack,
    output sq_hold, sq_empty, sq_busy, ex_iop,
    output agu_req, ld_req, alu_req, st_req
  );
endinterface

// File: rtl/iop_scheduler_fifo.sv
// iop_fifo: circular FIFO with a combinational head read.
// Ports:
//   - clk, a_rst (async active-low)
//   - push/wdata: write request
//   - pop: advance the head
//   - flush: empties the FIFO and overrides push/pop
//   - rdata: the head entry
//   - full, empty: derived from the registered count
// Behaviour:
//   - A push while full, or a pop while empty, is ignored.
//   - The head is read combinationally so the scheduler can take the next
//     entry in the same cycle its previous iop finishes.
module iop_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/iop_scheduler.sv
// iop_scheduler: in-order issue scheduler.
// Buffers decoded iops in iop_fifo and runs each one through its required
// steps (AGU -> LOAD -> ALU -> STORE), one req/ack handshake per step.
// Ports:
//   - clk
//   - a_rst: async active-low reset
//   - bus: iop_scheduler_if.slave, carrying the decode feed, flush,
//     the FIFO status, ex_iop and the four step handshakes.
module iop_scheduler
  import iop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IOP_W = 32
) (
  input logic           clk,
  input logic           a_rst,
  iop_scheduler_if.slave bus
);
  state_t           state_reg, state_next;
  logic [IOP_W-1:0] ex_iop_reg, ex_iop_next;
  logic [2:0]       init_reg, init_next;
  logic             pop, load_head, cur_ack;
  state_t           after;
  logic [IOP_W+2:0] head_word;
  logic [IOP_W-1:0] head_iop;
  logic [2:0]       head_init;
  logic             fifo_full, fifo_empty;

  iop_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IOP_W + 3)
  ) u_fifo (
    .clk   (clk),
    .a_rst (a_rst),
    .push  (bus.id_feed),
    .wdata ({bus.id_iop_init, bus.id_iop}),
    .pop   (pop),
    .flush (bus.flush),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_iop  = head_word[IOP_W-1:0];
  assign head_init = head_word[IOP_W+2:IOP_W];

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_reg  <= ST_IDLE;
      ex_iop_reg <= '0;
      init_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      ex_iop_reg <= ex_iop_next;
      init_reg   <= init_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ex_iop_next = ex_iop_reg;
    init_next   = init_reg;
    pop         = 1'b0;
    load_head   = 1'b0;
    after       = ST_IDLE;

    // An ack only counts while the matching req is high.
    // The reqs are decoded from state_reg.
    cur_ack = (state_reg == ST_AGU   && bus.agu_ack) ||
              (state_reg == ST_LOAD  && bus.ld_ack)  ||
              (state_reg == ST_ALU   && bus.alu_ack) ||
              (state_reg == ST_STORE && bus.st_ack);

    if (state_reg == ST_IDLE) begin
      load_head = !bus.flush && !fifo_empty;
    end else if (bus.flush && state_reg != ST_STORE) begin
      // A flush aborts any step except a store already under way.
      state_next = ST_IDLE;
    end else if (cur_ack) begin
      after = step_after(state_reg, init_reg, ex_iop_reg[ALU_ST_MEM]);
      if (after != ST_IDLE)
        state_next = after;
      else if (!bus.flush && !fifo_empty)
        load_head = 1'b1;  // chain into the next iop without a bubble
      else
        state_next = ST_IDLE;
    end

    if (load_head) begin
      pop         = 1'b1;
      ex_iop_next = head_iop;
      init_next   = head_init;
      // An entry with no steps yields ST_IDLE here and is simply retired.
      state_next  = step_after(ST_IDLE, head_init, head_iop[ALU_ST_MEM]);
    end
  end

  assign bus.agu_req  = (state_reg == ST_AGU);
  assign bus.ld_req   = (state_reg == ST_LOAD);
  assign bus.alu_req  = (state_reg == ST_ALU);
  assign bus.st_req   = (state_reg == ST_STORE);
  assign bus.ex_iop   = ex_iop_reg;
  assign bus.sq_busy  = (state_reg != ST_IDLE);
  assign bus.sq_hold  = fifo_full;
  assign bus.sq_empty = fifo_empty;
endmodule

// File: tb/tb_iop_scheduler.sv
// Self-checking testbench for iop_scheduler.
// Structure:
//   - Table-driven vectors.
//   - Hand-written corner-case sequences.
//   - A randomized run checked against a transaction-level model built from
//     a queue of pending entries and a list of remaining steps.
module tb_iop_scheduler;
  localparam int DEPTH = 4;
  localparam int IOP_W = 32;

  logic clk   = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  iop_scheduler_if #(.IOP_W(IOP_W)) bus();

  iop_scheduler #(.DEPTH(DEPTH), .IOP_W(IOP_W)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  req;  // {st, alu, ld, agu}
    logic        busy;
    logic [31:0] ex;
  } trace_t;

  typedef struct {
    logic [2:0] init;
    logic       st;
    logic [3:0] mask;   // steps expected to appear, {st, alu, ld, agu}
    int         steps;  // number of cycles with a req
  } sel_t;

  typedef struct {
    logic [31:0] iop;
    logic [2:0]  init;
  } ent_t;

  trace_t tr[5];
  sel_t   sel[8];

  // Reference model state for the randomized run
  ent_t        mq[$];
  int          msteps[$];
  logic [31:0] m_ex;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] reqs();
    return {bus.st_req, bus.alu_req, bus.ld_req, bus.agu_req};
  endfunction

  task automatic idle_inputs();
    bus.id_feed     = 1'b0;
    bus.id_iop      = '0;
    bus.id_iop_init = '0;
    bus.flush       = 1'b0;
    bus.agu_ack     = 1'b1;
    bus.ld_ack      = 1'b1;
    bus.alu_ack     = 1'b1;
    bus.st_ack      = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    a_rst = 1'b0;
    tick();
    tick();
    a_rst = 1'b1;
  endtask

  task automatic feed(input logic [31:0] iop, input logic [2:0] init);
    bus.id_feed     = 1'b1;
    bus.id_iop      = iop;
    bus.id_iop_init = init;
    tick();
    bus.id_feed     = 1'b0;
  endtask

  task automatic wait_req(input int idx, input string name);
    logic [3:0] r;
    int n;
    n = 0;
    r = reqs();
    while (!r[idx] && n < 50) begin
      tick();
      r = reqs();
      n++;
    end
    chk(name, 64'(r[idx]), 64'd1);
  endtask

  // Steps of an entry straight from the selection rules
  function automatic void load_steps(input ent_t e);
    msteps.delete();
    if (e.init[0])   msteps.push_back(0);
    if (!e.init[1])  msteps.push_back(1);
    if (e.init[2])   msteps.push_back(2);
    if (e.iop[22])   msteps.push_back(3);
  endfunction

  initial begin
    logic [31:0] v;
    logic [3:0]  m;
    int          n;
    logic [31:0] got[$];
    logic [31:0] a_iop, b_iop;

    idle_inputs();

    // ---------------- reset state ----------------
    a_rst = 1'b0;
    tick();
    chk("reset_outs", {57'd0, bus.sq_hold, bus.sq_empty, bus.sq_busy, reqs()}, 64'b0100000);
    chk("reset_ex_iop", 64'(bus.ex_iop), 64'd0);
    a_rst = 1'b1;

    // ---------------- single iop, cycle-by-cycle table ----------------
    tr[0] = '{4'b0000, 1'b0, 32'h0};
    tr[1] = '{4'b0001, 1'b1, 32'h0000_1234};
    tr[2] = '{4'b0010, 1'b1, 32'h0000_1234};
    tr[3] = '{4'b0100, 1'b1, 32'h0000_1234};
    tr[4] = '{4'b0000, 1'b0, 32'h0000_1234};
    do_reset();
    feed(32'h0000_1234, 3'b101);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("single_c%0d", i + 1), {27'd0, reqs(), bus.sq_busy, bus.ex_iop},
          {27'd0, tr[i].req, tr[i].busy, tr[i].ex});
      $display("single cycle %0d req=%b busy=%b ex=%h", i + 1, reqs(), bus.sq_busy, bus.ex_iop);
      tick();
    end

    // ---------------- step selection table ----------------
    sel[0] = '{3'b000, 1'b0, 4'b0010, 1};
    sel[1] = '{3'b001, 1'b1, 4'b1011, 3};
    sel[2] = '{3'b010, 1'b0, 4'b0000, 0};
    sel[3] = '{3'b011, 1'b1, 4'b1001, 2};
    sel[4] = '{3'b100, 1'b0, 4'b0110, 2};
    sel[5] = '{3'b101, 1'b1, 4'b1111, 4};
    sel[6] = '{3'b110, 1'b1, 4'b1100, 2};
    sel[7] = '{3'b111, 1'b0, 4'b0101, 2};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      v = $urandom;
      v[22] = sel[i].st;
      feed(v, sel[i].init);
      m = '0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
        m = m | reqs();
        if (|reqs()) n++;
        tick();
      end
      chk($sformatf("sel_mask_%0d", i), 64'(m), 64'(sel[i].mask));
      chk($sformatf("sel_steps_%0d", i), 64'(n), 64'(sel[i].steps));
      chk($sformatf("sel_idle_%0d", i), 64'(bus.sq_busy), 64'd0);
      $display("select init=%b st=%b steps=%b cycles=%0d", sel[i].init, sel[i].st, m, n);
    end

    // ---------------- full FIFO with stalled ALU ----------------
    do_reset();
    bus.alu_ack = 1'b0;
    bus.id_iop_init = 3'b110;
    bus.id_feed = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.id_iop = 32'h100 + 32'(k);
      tick();
    end
    chk("full_hold", 64'(bus.sq_hold), 64'd1);
    bus.id_iop = 32'h0000_dead;
    tick();
    bus.id_feed = 1'b0;
    chk("full_hold_after_drop", 64'(bus.sq_hold), 64'd1);
    bus.alu_ack = 1'b1;
    got.delete();
    for (int c = 0; c < 15; c++) begin
      if (bus.alu_req) begin
        got.push_back(bus.ex_iop);
        $display("full drain iop=%h", bus.ex_iop);
      end
      tick();
    end
    chk("full_count", 64'(got.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size())
        chk($sformatf("full_order_%0d", k), 64'(got[k]), 64'(32'h100 + 32'(k)));
    end
    chk("full_empty_end", 64'(bus.sq_empty), 64'd1);

    // ---------------- store with delayed ack ----------------
    do_reset();
    a_iop = 32'h0040_00aa;
    b_iop = 32'h0000_00bb;
    bus.st_ack = 1'b0;
    bus.id_feed = 1'b1;
    bus.id_iop_init = 3'b110;
    bus.id_iop = a_iop;
    tick();
    bus.id_iop = b_iop;
    tick();
    bus.id_feed = 1'b0;
    wait_req(3, "store_wait");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("store_hold_%0d", k), {28'd0, reqs(), bus.ex_iop}, {28'd0, 4'b1000, a_iop});
      $display("store cycle %0d req=%b ex=%h", k, reqs(), bus.ex_iop);
      if (k == 3) bus.st_ack = 1'b1;
      tick();
    end
    bus.st_ack = 1'b0;
    chk("store_next_alu", {28'd0, reqs(), bus.ex_iop}, {28'd0, 4'b0100, b_iop});

    // ---------------- flush during LOAD ----------------
    do_reset();
    bus.ld_ack = 1'b0;
    bus.id_feed = 1'b1;
    bus.id_iop_init = 3'b000;
    for (int k = 0; k < 3; k++) begin
      bus.id_iop = 32'h201 + 32'(k);
      tick();
    end
    bus.id_feed = 1'b0;
    chk("flush_ld_pre", {59'd0, reqs(), bus.sq_empty}, {59'd0, 4'b0010, 1'b0});
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_ld_post", {58'd0, reqs(), bus.sq_busy, bus.sq_empty}, {58'd0, 4'b0000, 1'b0, 1'b1});
    bus.ld_ack = 1'b1;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      m = m | reqs();
      tick();
    end
    chk("flush_ld_quiet", 64'(m), 64'd0);
    $display("flush in load done");

    // ---------------- flush during STORE ----------------
    do_reset();
    bus.st_ack = 1'b0;
    bus.id_feed = 1'b1;
    bus.id_iop = 32'h0040_0300;
    bus.id_iop_init = 3'b010;
    tick();
    bus.id_iop = 32'h0000_0301;
    bus.id_iop_init = 3'b110;
    tick();
    bus.id_feed = 1'b0;
    wait_req(3, "flush_st_wait");
    bus.flush = 1'b1;
    bus.id_feed = 1'b1;
    bus.id_iop = 32'h0000_0302;
    tick();
    bus.flush = 1'b0;
    bus.id_feed = 1'b0;
    chk("flush_st_hold0", {58'd0, reqs(), bus.sq_empty, bus.sq_busy}, {58'd0, 4'b1000, 1'b1, 1'b1});
    tick();
    chk("flush_st_hold1", {58'd0, reqs(), bus.sq_empty, bus.sq_busy}, {58'd0, 4'b1000, 1'b1, 1'b1});
    bus.st_ack = 1'b1;
    tick();
    bus.st_ack = 1'b0;
    chk("flush_st_done", {58'd0, reqs(), bus.sq_empty, bus.sq_busy}, {58'd0, 4'b0000, 1'b1, 1'b0});
    repeat (3) tick();
    chk("flush_st_quiet", {58'd0, reqs(), bus.sq_empty, bus.sq_busy}, {58'd0, 4'b0000, 1'b1, 1'b0});
    $display("flush in store done");

    // ---------------- asynchronous reset mid-ALU ----------------
    do_reset();
    bus.alu_ack = 1'b0;
    feed(32'h0000_0500, 3'b110);
    wait_req(2, "areset_wait");
    #2;
    a_rst = 1'b0;
    #1;
    chk("areset_outs", {61'd0, bus.alu_req, bus.sq_empty, bus.sq_busy}, {61'd0, 3'b010});
    chk("areset_ex_iop", 64'(bus.ex_iop), 64'd0);
    tick();
    a_rst = 1'b1;
    $display("async reset mid-alu done");

    // ---------------- randomized run against the model ----------------
    do_reset();
    mq.delete();
    msteps.delete();
    m_ex = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0]  exp_req;
      logic [3:0]  ack;
      logic        busy, done, last, take;
      int          qn;
      ent_t        e;

      exp_req = (msteps.size() != 0) ? (4'b0001 << msteps[0]) : 4'b0000;
      chk("rand", {25'd0, bus.sq_hold, bus.sq_empty, bus.sq_busy, reqs(), bus.ex_iop},
          {25'd0, mq.size() == DEPTH, mq.size() == 0, msteps.size() != 0, exp_req, m_ex});

      bus.id_feed     = ($urandom_range(0, 9) < 6);
      bus.id_iop      = $urandom;
      bus.id_iop_init = 3'($urandom_range(0, 7));
      bus.agu_ack     = 1'($urandom_range(0, 1));
      bus.ld_ack      = 1'($urandom_range(0, 1));
      bus.alu_ack     = 1'($urandom_range(0, 1));
      bus.st_ack      = 1'($urandom_range(0, 1));
      bus.flush       = ($urandom_range(0, 99) < 3);

      ack  = {bus.st_ack, bus.alu_ack, bus.ld_ack, bus.agu_ack};
      busy = (msteps.size() != 0);
      done = busy && ack[msteps[0]];
      qn   = mq.size();
      if (bus.flush) begin
        if (busy && (msteps[0] != 3 || done))
          msteps.delete();
        mq.delete();
      end else begin
        last = done && (msteps.size() == 1);
        take = (!busy || last) && (qn > 0);
        if (done)
          void'(msteps.pop_front());
        if (take) begin
          e = mq.pop_front();
          m_ex = e.iop;
          load_steps(e);
          $display("rand issue iop=%h init=%b steps=%0d", e.iop, e.init, msteps.size());
        end
        if (bus.id_feed && qn != DEPTH)
          mq.push_back('{bus.id_iop, bus.id_iop_init});
      end
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iop_scheduler.md
# iop_scheduler

In-order issue scheduler between the decode unit and the execution resources. Buffers decoded internal operations (iops) with their step-init flags in a small FIFO. Back-pressures decode through `sq_hold`. Sequences one iop at a time through its required steps, AGU → LOAD → ALU → STORE, with a req/ack handshake per step.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `IOP_W`, 32, iop width.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `a_rst`  in  1  reset; asynchronous, active-low.
- `id_feed`  in  1  decode pushes an entry this cycle.
- `id_iop`  in  IOP_W  iop word.
- `id_iop_init`  in  3  step flags: [2] ALU step valid; [1] no load (reg/imm/store operand); [0] AGU step needed.
- `flush`  in  1  pipeline flush (PC invalidation).
- `sq_hold`  out  1  FIFO full; decode must not feed.
- `sq_empty`  out  1  FIFO holds no entries.
- `sq_busy`  out  1  FSM not IDLE.
- `ex_iop`  out  IOP_W  iop currently executing; held stable for all of its steps.
- `agu_req` / `agu_ack`  out/in  1  AGU step handshake.
- `ld_req` / `ld_ack`  out/in  1  memory load handshake.
- `alu_req` / `alu_ack`  out/in  1  ALU step handshake.
- `st_req` / `st_ack`  out/in  1  memory store handshake.

## Operation
- **FIFO**
  - Each entry holds `{id_iop_init, id_iop}`, IOP_W+3 bits.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
  - A push occurs when `id_feed & ~sq_hold`. `id_feed` while `sq_hold` is high is ignored and the entry is dropped.
  - Simultaneous push and pop leave the count unchanged.
- **Step selection** for the popped entry `{init, iop}`:
  - AGU if `init[0]`.
  - LOAD if `~init[1]`.
  - ALU if `init[2]`.
  - STORE if `iop[22]` (alu_st_mem).
  - Steps run in the fixed order AGU, LOAD, ALU, STORE. Absent steps are skipped.
  - An entry with no steps completes in zero step cycles.
- **FSM states:** IDLE, AGU, LOAD, ALU, STORE.
  - IDLE with FIFO non-empty: pop the head, latch `ex_iop`/init, go to the first required step.
  - Step state X: assert `X_req`. On `X_ack` go to the next required step. If none remains, this is the last step: pop the next head if non-empty and go to its first step (no bubble), else go to IDLE.
  - Without ack, stay in X. Req and ex_iop are held.
- **Req outputs** are decoded from the state register only. The ack is sampled only while the matching req is high; stray acks are ignored.
- **Flush**
  - FIFO is emptied: pointers and count cleared.
  - FSM in AGU/LOAD/ALU: aborts to IDLE, no further req.
  - FSM in STORE: the store is not aborted. It stays in STORE until `st_ack`, then goes to IDLE with no pop (FIFO already empty).
  - A push in the same cycle as flush is discarded.
- **Reset** (async, any time, including mid-handshake):
  - state IDLE; pointers and count 0.
  - all `*_req` 0; `ex_iop` 0.
  - `sq_hold` 0, `sq_empty` 1, `sq_busy` 0.

## Timing
- `sq_hold` = (count == DEPTH), from registered count. A pop in the current cycle does not release hold until the next cycle.
- Latency: `id_feed` in cycle 0 into an empty, idle scheduler → entry written at end of cycle 0 → popped at end of cycle 1 → first req high in cycle 2.
- Each step lasts ≥ 1 cycle: req rises the cycle after entering the state and is high until and including the ack cycle.
- Back-to-back iops: the next iop's first req is asserted in the cycle after the previous last ack.
- Throughput is one step per cycle with acks tied high: iop with ALU only → 1 iop/cycle.

## Structure
- Shared package `iop_pkg` holds:
  - iop bit positions (ALU_ST_MEM = 22, MEM_IS_RMW = 4, MEM_WIDTH = 3);
  - init bit indices (INIT_ALU = 2, INIT_NOLD = 1, INIT_AGU = 0);
  - the state enum.
- One sub-module `iop_fifo` (parameterised DEPTH/width, push/pop/flush, count, full/empty). The scheduler instantiates it and holds the FSM plus step-selection logic.

## Test plan
- **Reset:** assert `a_rst`=0 mid-ALU step with `alu_req`=1 → `alu_req`=0, `sq_empty`=1, `sq_busy`=0 immediately, without waiting for a clock edge.
- **Single iop:** iop with `iop[22]`=0, init=3'b101, all acks tied 1 → `agu_req` high in cycle 2, `ld_req` in cycle 3, `alu_req` in cycle 4, no `st_req`, IDLE in cycle 5.
- **Full:**
  - Stall `alu_ack`=0, feed 5 iops with init=3'b110 → `sq_hold`=1 after 5 accepted (1 executing + DEPTH=4 queued); a 6th feed is dropped.
  - Release ack → all 5 complete in order, `ex_iop` values match the feed order.
- **Store:** iop with `iop[22]`=1, init=3'b110, `st_ack` delayed 3 cycles → `st_req` high 4 cycles, `ex_iop` stable, next iop's `alu_req` the cycle after `st_ack`.
- **Flush in LOAD:** 2 queued entries, FSM in LOAD → next cycle IDLE, `ld_req`=0, `sq_empty`=1, no further req.
- **Flush in STORE:** → `st_req` stays high until ack, then IDLE; a push coincident with the flush is discarded (`sq_empty` stays 1).
